// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each accepted request runs IDLE -> ACCESS -> RESP, or IDLE -> RESP when the address is out of range.
module ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_valid,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,

    input  logic              p1_valid,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,

    output logic              read_ram,
    output logic              write_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                port_q, port_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                read_ram_q, read_ram_d;
    logic                write_ram_q, write_ram_d;
    logic                p0_rsp_valid_q, p0_rsp_valid_d;
    logic                p1_rsp_valid_q, p1_rsp_valid_d;
    logic [DATA_W-1:0]   p0_rsp_rdata_q, p0_rsp_rdata_d;
    logic [DATA_W-1:0]   p1_rsp_rdata_q, p1_rsp_rdata_d;
    logic                p0_rsp_err_q, p0_rsp_err_d;
    logic                p1_rsp_err_q, p1_rsp_err_d;
    logic [DATA_W-1:0]   rd_latch_q, rd_latch_d;

    logic                idle;
    logic                grant_port;
    logic                accept;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                in_range;

    // On a tie the port that did not win last time is granted.
    assign idle       = (state_q == IDLE);
    assign grant_port = (p0_valid && p1_valid) ? ~last_q : (p1_valid && !p0_valid);
    assign p0_ready   = rst_n && idle && (p0_valid || p1_valid) && !grant_port;
    assign p1_ready   = rst_n && idle && grant_port;
    assign accept     = p0_ready || p1_ready;

    assign sel_write  = grant_port ? p1_write : p0_write;
    assign sel_addr   = grant_port ? p1_addr  : p0_addr;
    assign sel_wdata  = grant_port ? p1_wdata : p0_wdata;
    // The full address width takes part in the range check.
    assign in_range   = (sel_addr < ADDR_W'(DEPTH));

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        port_d         = port_q;
        write_d        = write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        read_ram_d     = 1'b0;
        write_ram_d    = 1'b0;
        p0_rsp_valid_d = 1'b0;
        p1_rsp_valid_d = 1'b0;
        p0_rsp_rdata_d = '0;
        p1_rsp_rdata_d = '0;
        p0_rsp_err_d   = 1'b0;
        p1_rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_d  = grant_port;
                    port_d  = grant_port;
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (in_range) begin
                        state_d     = ACCESS;
                        read_ram_d  = !sel_write;
                        write_ram_d = sel_write;
                    end else begin
                        state_d        = RESP;
                        p0_rsp_valid_d = !grant_port;
                        p1_rsp_valid_d = grant_port;
                        p0_rsp_err_d   = !grant_port;
                        p1_rsp_err_d   = grant_port;
                    end
                end
            end
            ACCESS: begin
                // The read latch was loaded on the falling edge inside this cycle.
                state_d        = RESP;
                p0_rsp_valid_d = !port_q;
                p1_rsp_valid_d = port_q;
                p0_rsp_rdata_d = (!port_q && !write_q) ? rd_latch_q : '0;
                p1_rsp_rdata_d = ( port_q && !write_q) ? rd_latch_q : '0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            port_q         <= 1'b0;
            write_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            read_ram_q     <= 1'b0;
            write_ram_q    <= 1'b0;
            p0_rsp_valid_q <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p0_rsp_rdata_q <= '0;
            p1_rsp_rdata_q <= '0;
            p0_rsp_err_q   <= 1'b0;
            p1_rsp_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            port_q         <= port_d;
            write_q        <= write_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            read_ram_q     <= read_ram_d;
            write_ram_q    <= write_ram_d;
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p0_rsp_rdata_q <= p0_rsp_rdata_d;
            p1_rsp_rdata_q <= p1_rsp_rdata_d;
            p0_rsp_err_q   <= p0_rsp_err_d;
            p1_rsp_err_q   <= p1_rsp_err_d;
        end
    end

    // RAM read data is only valid while clk is high, so capture it on the falling edge.
    always_comb begin
        rd_latch_d = rd_latch_q;
        if (read_ram_q) begin
            rd_latch_d = ram_out;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_latch_q <= '0;
        end else begin
            rd_latch_q <= rd_latch_d;
        end
    end

    assign read_ram       = read_ram_q;
    assign write_ram      = write_ram_q;
    assign ram_addr       = addr_q;
    assign ram_write_data = wdata_q;
    assign p0_rsp_valid   = p0_rsp_valid_q;
    assign p1_rsp_valid   = p1_rsp_valid_q;
    assign p0_rsp_rdata   = p0_rsp_rdata_q;
    assign p1_rsp_rdata   = p1_rsp_rdata_q;
    assign p0_rsp_err     = p0_rsp_err_q;
    assign p1_rsp_err     = p1_rsp_err_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data RAM (32 x 32-bit, combinational read gated by clk high, write on falling clk edge).
- Port 0 is the load/store unit; port 1 is the instruction fetch / debug loader.
- Grants one access at a time using round-robin and drives the RAM strobes for exactly one cycle.
- Latches read data on the falling edge and returns a one-cycle response to the granted requester.

Parameters:
- ADDR_W, 32, width of requester and RAM addresses
- DATA_W, 32, data width
- DEPTH, 32, number of valid RAM words; addresses >= DEPTH are rejected

Ports:
- clk  in  1  system clock; all state updates on the rising edge except the read-data latch (falling edge)
- rst_n  in  1  asynchronous, active-low reset
- p0_valid  in  1  port 0 request valid; held until accepted
- p0_write  in  1  port 0 request is a write (1) or read (0)
- p0_addr  in  ADDR_W  port 0 word address
- p0_wdata  in  DATA_W  port 0 write data
- p0_ready  out  1  port 0 request accepted this cycle
- p0_rsp_valid  out  1  port 0 response pulse
- p0_rsp_rdata  out  DATA_W  port 0 read data (0 for writes and errors)
- p0_rsp_err  out  1  port 0 address out of range
- p1_valid, p1_write, p1_addr, p1_wdata, p1_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err  same as port 0, for port 1
- read_ram  out  1  RAM read strobe
- write_ram  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_write_data  out  DATA_W  RAM write data
- ram_out  in  DATA_W  RAM read data; valid only while clk high and read_ram high

Behaviour:
- States:
  - IDLE: ready to accept a request.
  - ACCESS: RAM strobe cycle.
  - RESP: response cycle.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Every output goes to 0: read_ram, write_ram, ram_addr, ram_write_data, all ready, rsp_valid, rsp_rdata and rsp_err.
  - Internal read latch clears to 0.
  - Round-robin pointer set so port 0 wins the first tie.
- Grant (IDLE only):
  - pN_ready = (state==IDLE) && grant==N. It is combinational and never asserted outside IDLE.
  - Only one valid: that port is granted.
  - Both valid: the port not granted last wins. The pointer updates only on an accepted request.
- Accept (rising edge with valid && ready):
  - Registers addr, wdata, write and port id.
  - Next state is ACCESS if addr < DEPTH, otherwise RESP with err pending.
- ACCESS (exactly one cycle):
  - ram_addr and ram_write_data come from registered values.
  - Exactly one of read_ram / write_ram is high for the whole cycle.
  - The RAM performs the write at the falling edge inside this cycle.
  - For reads, the falling edge inside ACCESS latches ram_out into the read latch.
  - Next state is RESP. All RAM strobes are 0 in every other state.
- RESP (one cycle):
  - rsp_valid is high only for the granted port.
  - rsp_rdata is the latch value for an in-range read, otherwise 0.
  - rsp_err = 1 for an out-of-range request.
  - Next state is IDLE.
- Latency and throughput:
  - Request accepted at edge N gives rsp_valid high in cycle N+2 (in range) or N+1 (error).
  - Throughput is at most one access per 3 cycles.
- Out-of-range:
  - No RAM strobe at all.
  - Latch untouched.
  - rdata = 0, err = 1.
- Simultaneous events:
  - A new valid arriving during ACCESS/RESP waits; ready stays 0.
  - A requester may present its next request in the same cycle as its rsp_valid; it is accepted no earlier than the following IDLE cycle.
- Reset mid-operation:
  - Strobes drop immediately on rst_n low, so an in-flight write is suppressed if reset precedes the falling edge.
  - No response is issued for the aborted request.
- Unused address bits above log2(DEPTH) participate only in the range check.

Test Plan:
- Port 0 write addr 5 data 0xDEADBEEF, then port 0 read addr 5 -> write_ram high exactly 1 cycle; read rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after each accept.
- p0 and p1 both hold valid reads for 4 requests each -> grants alternate 0,1,0,1,...; first grant to port 0; no rsp_valid on the non-granted port.
- Port 1 read addr 40 (DEPTH 32) -> no read_ram/write_ram pulse; p1_rsp_valid 1 cycle after accept with rsp_err = 1, rdata = 0.
- p1_valid rises while port 0 is in ACCESS -> p1_ready stays 0 until IDLE, then p1 is granted; p0 response unaffected.
- Port 0 write addr 3 data 0x55 with rst_n pulled low mid-ACCESS before the falling edge -> all outputs 0 immediately; after reset, read addr 3 returns the prior contents, not 0x55.
- Back-to-back p0 reads addr 0..15 with valid held continuously -> one accept every 3 cycles; rdata matches the written/preloaded words in order.
